// File: rtl/fetch_unit_if.sv
// Decode-side and programming bus of the fetch unit. The fetch unit uses the
// master view; the decode stage and programmer use the slave view.
interface fetch_unit_if #(
  parameter int INSTR_W = 8,
  parameter int PC_W    = 4
);
  logic               en;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc_out;
  logic               halted;

  modport master (
    input  en, prog_we, prog_addr, prog_data, redirect_valid, redirect_pc,
           instr_ready,
    output instr_out, instr_pc, instr_valid, pc_out, halted
  );

  modport slave (
    output en, prog_we, prog_addr, prog_data, redirect_valid, redirect_pc,
           instr_ready,
    input  instr_out, instr_pc, instr_valid, pc_out, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: programmable instruction memory, fetch PC,
// one-cycle synchronous read and a small prefetch queue feeding decode.
module fetch_unit #(
  parameter int                 INSTR_W     = 8,
  parameter int                 PC_W        = 4,
  parameter int                 DEPTH       = 2,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int MEM_DEPTH = 1 << PC_W;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] mem [MEM_DEPTH];
  logic [INSTR_W-1:0] rd_data;

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    inflight_pc;
  logic               inflight;
  logic               halted_q;

  logic [INSTR_W-1:0] q_data [DEPTH];
  logic [PC_W-1:0]    q_pc   [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               q_valid;
  logic               pop;
  logic               push;
  logic               issue;
  int                 used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign q_valid = (count != '0);
  assign pop     = q_valid & bus.instr_ready;
  // Once halted, anything still in flight was fetched past the HALT word.
  assign push    = inflight & ~halted_q;

  // Credit check counts the in-flight read so a returning word always fits.
  always_comb begin
    used  = int'(count) + int'(inflight) - int'(pop);
    issue = bus.en & ~halted_q & ~bus.redirect_valid & ~rst & (used < DEPTH);
  end

  // Memory has no reset; a same-address read/write returns the old word.
  always_ff @(posedge clk) begin
    if (bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_data;
    if (issue)
      rd_data <= mem[fetch_pc];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halted_q    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      halted_q <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        q_data[tail] <= rd_data;
        q_pc[tail]   <= inflight_pc;
        tail         <= next_ptr(tail);
        if (rd_data == HALT_OPCODE)
          halted_q <= 1'b1;
      end
      if (pop)
        head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_W'(1);
      end
    end
  end

  assign bus.instr_valid = q_valid;
  assign bus.instr_out   = q_valid ? q_data[head] : '0;
  assign bus.instr_pc    = q_valid ? q_pc[head] : '0;
  assign bus.pc_out      = fetch_pc;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit, compared every cycle against a queue-based
// reference model of the fetch front end.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if #(.INSTR_W(8), .PC_W(4)) bus ();

  fetch_unit #(.INSTR_W(8), .PC_W(4), .DEPTH(DEPTH), .HALT_OPCODE(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] data;
  } entry_t;

  logic [7:0] m_mem [16];
  entry_t     m_q[$];
  bit         m_infl;
  entry_t     m_fl;
  logic [3:0] m_fpc;
  bit         m_halted;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, written against the queue model.
  task automatic modelStep(input bit r, input bit e, input bit we,
                           input logic [3:0] wa, input logic [7:0] wd,
                           input bit rv, input logic [3:0] rp, input bit rdy);
    bit     do_pop;
    bit     do_issue;
    entry_t rd;
    if (r) begin
      m_fpc = 0; m_q.delete(); m_infl = 0; m_halted = 0;
    end else if (rv) begin
      m_fpc = rp; m_q.delete(); m_infl = 0; m_halted = 0;
    end else begin
      do_pop   = (m_q.size() > 0) && rdy;
      do_issue = e && !m_halted &&
                 (m_q.size() + int'(m_infl) - int'(do_pop) < DEPTH);
      rd.pc    = m_fpc;
      rd.data  = m_mem[m_fpc];
      if (do_pop) void'(m_q.pop_front());
      if (m_infl && !m_halted) begin
        m_q.push_back(m_fl);
        if (m_fl.data == 8'hFF) m_halted = 1;
      end
      m_infl = do_issue;
      if (do_issue) begin
        m_fl  = rd;
        m_fpc = m_fpc + 4'd1;
      end
    end
    if (we) m_mem[wa] = wd;
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit we,
                               input logic [3:0] wa, input logic [7:0] wd,
                               input bit rv, input logic [3:0] rp, input bit rdy);
    @(negedge clk);
    checkOutput("instr_valid", 32'(bus.instr_valid), 32'(m_q.size() > 0));
    checkOutput("instr_out", 32'(bus.instr_out),
                m_q.size() > 0 ? 32'(m_q[0].data) : 32'd0);
    checkOutput("instr_pc", 32'(bus.instr_pc),
                m_q.size() > 0 ? 32'(m_q[0].pc) : 32'd0);
    checkOutput("pc_out", 32'(bus.pc_out), 32'(m_fpc));
    checkOutput("halted", 32'(bus.halted), 32'(m_halted));
    rst                = r;
    bus.en             = e;
    bus.prog_we        = we;
    bus.prog_addr      = wa;
    bus.prog_data      = wd;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.instr_ready    = rdy;
    @(posedge clk);
    modelStep(r, e, we, wa, wd, rv, rp, rdy);
  endtask

  task automatic runCycles(input int n, input bit e, input bit rdy);
    for (int i = 0; i < n; i++)
      applyStimulus(0, e, 0, 4'd0, 8'd0, 0, 4'd0, rdy);
  endtask

  task automatic redirectTo(input logic [3:0] target, input bit rdy);
    applyStimulus(0, 1, 0, 4'd0, 8'd0, 1, target, rdy);
  endtask

  logic [7:0] init_words [4];
  logic [7:0] rnd_word;

  initial begin
    rst = 1; bus.en = 0; bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
    m_q.delete(); m_infl = 0; m_fpc = 0; m_halted = 0;
    m_fl.pc = 0; m_fl.data = 0;
    for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
    @(posedge clk);

    init_words[0] = 8'h08; init_words[1] = 8'h19;
    init_words[2] = 8'h2A; init_words[3] = 8'h3B;
    for (int a = 0; a < 16; a++) begin
      rnd_word = 8'($urandom_range(8'hFE));
      applyStimulus(1, 0, 1, 4'(a), (a < 4) ? init_words[a] : rnd_word, 0, 4'd0, 0);
    end
    applyStimulus(1, 0, 0, 4'd0, 8'd0, 0, 4'd0, 0);

    // Basic stream, then back-pressure, then redirect with a full queue.
    runCycles(7, 1, 1);
    runCycles(5, 1, 0);
    runCycles(4, 1, 1);
    runCycles(3, 1, 0);
    redirectTo(4'd9, 0);
    runCycles(5, 1, 1);

    // Halt at address 4, then restart from 0 after clearing the halt word.
    applyStimulus(0, 0, 1, 4'd4, 8'hFF, 0, 4'd0, 1);
    redirectTo(4'd0, 1);
    runCycles(10, 1, 1);
    applyStimulus(0, 1, 1, 4'd4, 8'h44, 0, 4'd0, 1);
    redirectTo(4'd0, 1);
    runCycles(4, 1, 1);

    // Wrap past address 15.
    redirectTo(4'd12, 1);
    runCycles(8, 1, 1);

    // Reset with queue full and a read in flight; memory must survive.
    runCycles(3, 1, 0);
    applyStimulus(1, 1, 0, 4'd0, 8'd0, 1, 4'd7, 0);
    runCycles(6, 1, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) == 0),
                    ($urandom_range(7) != 0),
                    ($urandom_range(15) == 0),
                    4'($urandom_range(15)),
                    ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(255)),
                    ($urandom_range(15) == 0),
                    4'($urandom_range(15)),
                    ($urandom_range(3) != 0));
    end
    runCycles(2, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
